// File: rtl/mux4_rr_sched_if.sv
// rtl/mux4_rr_sched_if.sv - request/grant/select bundle for the 4-way round-robin mux scheduler
interface mux4_rr_sched_if;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic       S;
    logic       T;
    logic       V;

    modport master (input REQ, output GNT, output S, output T, output V);
    modport slave  (output REQ, input GNT, input S, input T, input V);
endinterface

// File: rtl/mux4_rr_sched.sv
// rtl/mux4_rr_sched.sv - round-robin scheduler driving a shared 4:1 mux select with bounded hold
module mux4_rr_sched #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic              CLK,
    input  logic              RST,
    mux4_rr_sched_if.master   bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             v_q, v_d;

    logic [3:0]       others;
    logic [1:0]       g_next;
    logic [2:0]       win;

    // Returns {found, index} of the first set bit at or after start, wrapping modulo 4.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        v_d     = v_q;
        g_next  = sel_q + 2'd1;
        others  = bus.REQ & ~gnt_q;
        win     = 3'b000;
        case (state_q)
            IDLE: begin
                win = pick(bus.REQ, ptr_q);
                if (win[2]) begin
                    gnt_d   = 4'b0001 << win[1:0];
                    sel_d   = win[1:0];
                    v_d     = 1'b1;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!bus.REQ[sel_q]) begin
                    ptr_d = g_next;
                    win   = pick(others, g_next);
                    if (win[2]) begin
                        gnt_d = 4'b0001 << win[1:0];
                        sel_d = win[1:0];
                        cnt_d = '0;
                    end else begin
                        // select is left where it was so the datapath does not glitch
                        gnt_d   = 4'b0000;
                        v_d     = 1'b0;
                        state_d = IDLE;
                    end
                end else if ((|others) && (cnt_q == HOLD_LAST)) begin
                    ptr_d = g_next;
                    win   = pick(others, g_next);
                    gnt_d = 4'b0001 << win[1:0];
                    sel_d = win[1:0];
                    cnt_d = '0;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            v_q     <= v_d;
        end
    end

    assign bus.GNT = gnt_q;
    assign bus.S   = sel_q[0];
    assign bus.T   = sel_q[1];
    assign bus.V   = v_q;
endmodule

// File: doc/mux4_rr_sched.md
Name: mux4_rr_sched

Overview:
- Round-robin scheduler that shares one 4:1 mux resource (a 74AC153 half, or any mapped $_MUX4_) between four requesters.
- Drives the mux select pair {T,S} and a one-hot grant vector.
- Enforces a bounded hold time so that no requester starves the shared mux.
- Sits beside the mux cell in 74xx-mapped designs, e.g. a shared bus source select.

Parameters:
- MAX_HOLD, 4: maximum consecutive grant cycles for one requester while any other requester is pending. Legal range 1..255. A value of 1 rotates every cycle under contention.
- CNT_W, 8: width of the internal hold counter. Must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- REQ  input  4  request lines. REQ[i] is held high while requester i wants the mux.
- GNT  output 4  one-hot grant, registered. All-zero when idle.
- S    output 1  mux select LSB, registered. Wire to the mux S input.
- T    output 1  mux select MSB, registered. Wire to the mux T input. {T,S} = index of the granted requester.
- V    output 1  grant valid, registered. Equals |GNT.

Behaviour:
- Interface:
  - Single clock CLK.
  - RST is synchronous and active-high, sampled only on the CLK rising edge.
  - All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset:
  - GNT=4'b0000, {T,S}=2'b00, V=0.
  - Priority pointer PTR=0, hold counter CNT=0, state=IDLE.
  - RST overrides every other event, including mid-grant. The grant drops on the same edge.
- Priority search:
  - Search REQ starting at index PTR and ascending modulo 4, i.e. PTR, PTR+1, PTR+2, PTR+3 with wrap from 3 to 0.
  - The first set bit wins.
- State IDLE (V=0):
  - No REQ bit set: stay in IDLE. {T,S} retains its last value to avoid select glitching on the datapath.
  - Any REQ bit set: on the next edge, GNT=onehot(w), {T,S}=w, V=1, CNT=0, state→GRANT, where w is the search winner.
  - Latency from REQ rising to GNT is 1 cycle.
- State GRANT (granted index g), evaluated each edge in this priority order:
  1. REQ[g]=0 (release):
     - PTR←(g+1) mod 4.
     - Search the remaining requests starting from g+1. If there is a winner w, grant w on this same edge with CNT=0, leaving no idle gap.
     - Otherwise GNT=0, V=0, state→IDLE, {T,S} held.
  2. REQ[g]=1, another REQ bit set, and CNT==MAX_HOLD-1 (forced rotation):
     - PTR←(g+1) mod 4.
     - Grant the winner of the search from g+1, excluding g, with CNT=0.
  3. REQ[g]=1, no forced rotation:
     - Keep the grant.
     - CNT increments, saturating at MAX_HOLD-1.
     - With no contention, CNT stays saturated and the grant persists indefinitely. A new competing request then causes rotation on its first sampled edge.
- Invariants:
  - GNT is always one-hot or zero.
  - V==|GNT.
  - When V=1, {T,S}==index(GNT).
  - Any continuously asserted REQ is granted within 3*MAX_HOLD+1 cycles.
- Simultaneous events:
  - A release and a new request on the same edge are resolved by the release rule (1).
  - A requester whose REQ drops on the same edge it would be granted is not granted, because only sampled REQ counts.

Test Plan:
- Reset, then REQ=4'b0100 → one edge later GNT=4'b0100, {T,S}=2'b10, V=1. After REQ=0 → next edge GNT=0, V=0, {T,S} stays 2'b10.
- MAX_HOLD=4, REQ=4'b1111 held from reset → grants 0,1,2,3,0 in sequence, each exactly 4 cycles, with no idle cycle between grants. {T,S} steps 00,01,10,11,00.
- Requester 1 granted alone for 10 cycles, then REQ[3] rises → GNT moves to 4'b1000 on the first edge after REQ[3] is sampled (counter already saturated).
- Back-to-back handoff: 0 granted with REQ=4'b0101, then REQ drops to 4'b0100 → GNT goes 4'b0001→4'b0100 on a single edge with V never low.
- RST asserted while GNT=4'b0010 → next edge all outputs 0, PTR=0. Then REQ=4'b1010 → GNT=4'b0010.
- MAX_HOLD=1, REQ=4'b1001 → GNT alternates 4'b0001/4'b1000 every cycle. Checker asserts one-hot, V==|GNT and {T,S}==index(GNT) on every cycle.
